hub75_pixel_writer: RTL

Upstream feeder for the HUB75 frame buffer. Accepts a raster-ordered RGB pixel stream with valid/ready handshake and start-of-frame/end-of-line markers, tracks the (x,y) position, and drives the frame buffer write port (address, packed {R,G,B} data, write enable). Malformed frames are detected, counted and resynchronised at the next start-of-frame, so the display scanner never sees pixels written to wrong addresses.

---
 rtl/hub75_pkg.sv | 38 +++
 rtl/hub75_pixel_writer_if.sv | 21 ++
 rtl/hub75_pixel_writer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 pixel path: writer FSM states,
// the packed {R,G,B} pixel type and the framing-error counter helper.
package hub75_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } writer_state_e;

    localparam int bpp_c           = 8;
    localparam int err_cnt_width_c = 8;

    typedef struct packed {
        logic [bpp_c-1:0] r;
        logic [bpp_c-1:0] g;
        logic [bpp_c-1:0] b;
    } pixel_t;

    // Next framing-error count: a clear wins over the old value, but an error
    // in the same cycle still counts as one; otherwise saturate at all-ones.
    function automatic logic [err_cnt_width_c-1:0] err_cnt_next(
        input logic [err_cnt_width_c-1:0] cnt,
        input logic                       err,
        input logic                       clr
    );
        logic [err_cnt_width_c-1:0] res;
        if (clr) begin
            res = err ? {{(err_cnt_width_c-1){1'b0}}, 1'b1} : {err_cnt_width_c{1'b0}};
        end else if (err && (cnt != {err_cnt_width_c{1'b1}})) begin
            res = cnt + {{(err_cnt_width_c-1){1'b0}}, 1'b1};
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/hub75_pixel_writer_if.sv
// Raster-ordered pixel stream with valid/ready handshake and
// start-of-frame / end-of-line markers.
interface hub75_pixel_writer_if #(
    parameter int bpp_p = 8
);
    logic [3*bpp_p-1:0] i_pix_data;
    logic               i_pix_valid;
    logic               i_pix_sof;
    logic               i_pix_eol;
    logic               o_pix_ready;

    modport master (
        output i_pix_data, i_pix_valid, i_pix_sof, i_pix_eol,
        input  o_pix_ready
    );

    modport slave (
        input  i_pix_data, i_pix_valid, i_pix_sof, i_pix_eol,
        output o_pix_ready
    );
endinterface

// File: rtl/hub75_pixel_writer.sv
// Feeds the HUB75 frame buffer from a raster pixel stream: tracks (x,y),
// emits one registered write per accepted in-frame beat, and drops beats of
// malformed frames until the next start-of-frame resynchronises the writer.
module hub75_pixel_writer
    import hub75_pkg::*;
#(
    parameter  int hpixel_p     = 64,
    parameter  int vpixel_p     = 64,
    parameter  int bpp_p        = 8,
    localparam int addr_width_p = ((hpixel_p * vpixel_p) > 1) ? $clog2(hpixel_p * vpixel_p) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    hub75_pixel_writer_if.slave        pix,
    input  logic                       i_stall,
    output logic [addr_width_p-1:0]    o_framebuf_wr_addr,
    output logic [3*bpp_p-1:0]         o_framebuf_wr_data,
    output logic                       o_framebuf_wr_en,
    output logic                       o_frame_done,
    output logic                       o_sync_err,
    output logic [err_cnt_width_c-1:0] o_err_count,
    input  logic                       i_err_clr
);

    localparam int x_w = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
    localparam int y_w = (vpixel_p > 1) ? $clog2(vpixel_p) : 1;
    localparam logic [x_w-1:0] x_last_c = x_w'(hpixel_p - 1);
    localparam logic [y_w-1:0] y_last_c = y_w'(vpixel_p - 1);

    writer_state_e            state_r, next_state_s;
    logic [x_w-1:0]           x_r, x_next_s, bx_s;
    logic [y_w-1:0]           y_r, y_next_s, by_s;
    logic                     accept_s, wr_s, done_s, err_s;
    logic [addr_width_p-1:0]  addr_s;

    // Ready depends only on stall and reset so upstream never waits on FSM state.
    assign pix.o_pix_ready = ~i_stall & ~rst;

    // Next-state, position update and write/error decode for the accepted beat.
    always_comb begin
        accept_s     = pix.i_pix_valid & pix.o_pix_ready;
        next_state_s = state_r;
        x_next_s     = x_r;
        y_next_s     = y_r;
        wr_s         = 1'b0;
        done_s       = 1'b0;
        err_s        = 1'b0;

        case (state_r)
            ST_WRITE: begin
                wr_s  = accept_s;
                err_s = accept_s & pix.i_pix_sof;
            end
            ST_IDLE, ST_DROP: begin
                wr_s = accept_s & pix.i_pix_sof;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase

        // A start-of-frame beat always lands at the origin, whatever came before.
        if (pix.i_pix_sof) begin
            bx_s = {x_w{1'b0}};
            by_s = {y_w{1'b0}};
        end else begin
            bx_s = x_r;
            by_s = y_r;
        end

        addr_s = addr_width_p'(by_s) * addr_width_p'(hpixel_p) + addr_width_p'(bx_s);

        if (wr_s) begin
            if (bx_s == x_last_c) begin
                if (pix.i_pix_eol) begin
                    x_next_s = {x_w{1'b0}};
                    if (by_s == y_last_c) begin
                        done_s       = 1'b1;
                        y_next_s     = {y_w{1'b0}};
                        next_state_s = ST_IDLE;
                    end else begin
                        y_next_s     = y_w'(by_s + 1'b1);
                        next_state_s = ST_WRITE;
                    end
                end else begin
                    err_s        = 1'b1;
                    next_state_s = ST_DROP;
                end
            end else if (pix.i_pix_eol) begin
                err_s        = 1'b1;
                next_state_s = ST_DROP;
            end else begin
                x_next_s     = x_w'(bx_s + 1'b1);
                y_next_s     = by_s;
                next_state_s = ST_WRITE;
            end
        end else begin
            x_next_s = x_r;
        end
    end

    // FSM state and raster position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            x_r     <= {x_w{1'b0}};
            y_r     <= {y_w{1'b0}};
        end else begin
            state_r <= next_state_s;
            x_r     <= x_next_s;
            y_r     <= y_next_s;
        end
    end

    // Registered frame-buffer write port and frame/error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_framebuf_wr_en   <= 1'b0;
            o_framebuf_wr_addr <= {addr_width_p{1'b0}};
            o_framebuf_wr_data <= {(3*bpp_p){1'b0}};
            o_frame_done       <= 1'b0;
            o_sync_err         <= 1'b0;
        end else begin
            o_framebuf_wr_en <= wr_s;
            o_frame_done     <= done_s;
            o_sync_err       <= err_s;
            if (wr_s) begin
                o_framebuf_wr_addr <= addr_s;
                o_framebuf_wr_data <= pix.i_pix_data;
            end else begin
                o_framebuf_wr_addr <= o_framebuf_wr_addr;
                o_framebuf_wr_data <= o_framebuf_wr_data;
            end
        end
    end

    // Saturating framing-error counter with synchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err_count <= {err_cnt_width_c{1'b0}};
        end else begin
            o_err_count <= err_cnt_next(o_err_count, err_s, i_err_clr);
        end
    end

endmodule
